// File: rtl/bus_pkg.sv
// Shared definitions for the bus pipeline slice: default widths, sideband
// flag bit positions and the parity helper used by both channels.
package bus_pkg;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_FLAG_W = 8;

   // Bit positions of the sideband flags carried by the flag pipe.
   typedef enum int unsigned {
      FLAG_ACK    = 0,
      FLAG_REQ_W1 = 1,
      FLAG_REQ_W2 = 2,
      FLAG_REQ_R1 = 3,
      FLAG_REQ_R2 = 4,
      FLAG_ABORT  = 5
   } flag_idx_e;

   // Even parity bit over a payload zero-extended to 64 bits; zero
   // extension leaves the parity unchanged.
   function automatic logic parity_even(input logic [63:0] payload);
      return ^payload;
   endfunction

endpackage

// File: rtl/bus_pipeline_n_if.sv
// Master/slave handshake bundle for the REQ and RSP ready/valid channels.
interface bus_pipeline_n_if
   import bus_pkg::*;
#(
   parameter int DATA_W = BUS_DATA_W
);
   logic              req_valid;
   logic              req_we;
   logic [DATA_W-1:0] req_data;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready;

   modport master (
      output req_valid, req_we, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bus_skid_stage.sv
// One registered skid stage: output register plus one-word skid buffer.
// in_ready comes straight from a flop, so there is no combinational ready path.
module bus_skid_stage
   import bus_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q,  out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q,  skid_data_d;

   // Next-state: refill output from skid first (keeps order), else from input; park input in skid on stall.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_valid;
            if (in_valid) begin
               out_data_d = in_data;
            end else begin
               out_data_d = out_data_q;
            end
         end
      end else if (in_valid && !skid_valid_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // Stage registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= {W{1'b0}};
         skid_valid_q <= 1'b0;
         skid_data_q  <= {W{1'b0}};
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
endmodule

// File: rtl/bus_pipeline_n.sv
// Back-pressure-aware REQ/RSP pipeline between bus master and slaves, with a
// fixed-latency sideband flag pipe and synchronous flush.
// Optional feature: define BUS_PIPE_PARITY_EN to carry an even parity bit per
// word and raise a sticky parity_err on a mismatch at delivery.
module bus_pipeline_n
   import bus_pkg::*;
#(
   parameter int DATA_W      = BUS_DATA_W,
   parameter int REQ_STAGES  = 2,
   parameter int RSP_STAGES  = 2,
   parameter int FLAG_W      = BUS_FLAG_W,
   parameter int FLAG_STAGES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   bus_pipeline_n_if.slave   up,
   bus_pipeline_n_if.master  dn,
   input  logic [FLAG_W-1:0] flags,
   output logic [FLAG_W-1:0] flags_o,
   output logic              parity_err
);
`ifdef BUS_PIPE_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   // REQ word = {parity?, we, data}; RSP word = {parity?, data}.
   localparam int REQ_W = DATA_W + 1 + PAR_W;
   localparam int RSP_W = DATA_W + PAR_W;

   logic             req_v [0:REQ_STAGES];
   logic             req_r [0:REQ_STAGES];
   logic [REQ_W-1:0] req_d [0:REQ_STAGES];
   logic             rsp_v [0:RSP_STAGES];
   logic             rsp_r [0:RSP_STAGES];
   logic [RSP_W-1:0] rsp_d [0:RSP_STAGES];

   // Channel entry points; parity is generated once at the stage-0 input.
   assign req_v[0] = up.req_valid;
   assign rsp_v[0] = dn.rsp_valid;
`ifdef BUS_PIPE_PARITY_EN
   assign req_d[0] = {parity_even(64'({up.req_we, up.req_data})), up.req_we, up.req_data};
   assign rsp_d[0] = {parity_even(64'(dn.rsp_data)), dn.rsp_data};
`else
   assign req_d[0] = {up.req_we, up.req_data};
   assign rsp_d[0] = dn.rsp_data;
`endif

   // With zero stages the index-0 wires join directly, giving a passthrough.
   assign up.req_ready = req_r[0];
   assign dn.req_valid = req_v[REQ_STAGES];
   assign dn.req_we    = req_d[REQ_STAGES][DATA_W];
   assign dn.req_data  = req_d[REQ_STAGES][DATA_W-1:0];
   assign req_r[REQ_STAGES] = dn.req_ready;

   assign dn.rsp_ready = rsp_r[0];
   assign up.rsp_valid = rsp_v[RSP_STAGES];
   assign up.rsp_data  = rsp_d[RSP_STAGES][DATA_W-1:0];
   assign rsp_r[RSP_STAGES] = up.rsp_ready;

   for (genvar i = 0; i < REQ_STAGES; i++) begin : g_req
      bus_skid_stage #(.W(REQ_W)) u_stage (
         .clk(clk), .reset(reset), .flush(flush),
         .in_valid(req_v[i]), .in_data(req_d[i]), .in_ready(req_r[i]),
         .out_valid(req_v[i+1]), .out_data(req_d[i+1]), .out_ready(req_r[i+1])
      );
   end

   for (genvar i = 0; i < RSP_STAGES; i++) begin : g_rsp
      bus_skid_stage #(.W(RSP_W)) u_stage (
         .clk(clk), .reset(reset), .flush(flush),
         .in_valid(rsp_v[i]), .in_data(rsp_d[i]), .in_ready(rsp_r[i]),
         .out_valid(rsp_v[i+1]), .out_data(rsp_d[i+1]), .out_ready(rsp_r[i+1])
      );
   end

`ifdef BUS_PIPE_PARITY_EN
   logic req_perr_s, rsp_perr_s;
   logic parity_err_q, parity_err_d;

   assign req_perr_s = dn.req_valid && dn.req_ready &&
      (parity_even(64'(req_d[REQ_STAGES][DATA_W:0])) != req_d[REQ_STAGES][REQ_W-1]);
   assign rsp_perr_s = up.rsp_valid && up.rsp_ready &&
      (parity_even(64'(rsp_d[RSP_STAGES][DATA_W-1:0])) != rsp_d[RSP_STAGES][RSP_W-1]);

   // Sticky error: any delivered word with bad parity sets it until reset.
   always_comb begin
      parity_err_d = parity_err_q || req_perr_s || rsp_perr_s;
   end

   // Error flag register; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   if (FLAG_STAGES == 0) begin : g_flag_pass
      assign flags_o = flags;
   end else begin : g_flag
      logic [FLAG_W-1:0] flag_q [FLAG_STAGES];
      logic [FLAG_W-1:0] flag_d [FLAG_STAGES];

      // Shift-register next state: no back-pressure, no flush.
      always_comb begin
         flag_d[0] = flags;
         for (int i = 1; i < FLAG_STAGES; i++) begin
            flag_d[i] = flag_q[i-1];
         end
      end

      // Flag pipe registers, cleared only by reset.
      always_ff @(posedge clk) begin
         for (int i = 0; i < FLAG_STAGES; i++) begin
            if (reset) begin
               flag_q[i] <= {FLAG_W{1'b0}};
            end else begin
               flag_q[i] <= flag_d[i];
            end
         end
      end

      assign flags_o = flag_q[FLAG_STAGES-1];
   end
endmodule

// File: tb/tb_bus_pipeline_n.sv
// Self-checking bench for bus_pipeline_n: directed steps plus a randomized
// phase, checked against queue-based models of both channels and the flag pipe.
module tb_bus_pipeline_n;
   localparam int DATA_W      = 32;
   localparam int REQ_STAGES  = 2;
   localparam int RSP_STAGES  = 2;
   localparam int FLAG_W      = 8;
   localparam int FLAG_STAGES = 1;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [FLAG_W-1:0] flags;
   logic [FLAG_W-1:0] flags_o;
   logic              parity_err;

   bus_pipeline_n_if #(.DATA_W(DATA_W)) up ();
   bus_pipeline_n_if #(.DATA_W(DATA_W)) dn ();

   bus_pipeline_n #(
      .DATA_W(DATA_W), .REQ_STAGES(REQ_STAGES), .RSP_STAGES(RSP_STAGES),
      .FLAG_W(FLAG_W), .FLAG_STAGES(FLAG_STAGES)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .up(up), .dn(dn),
      .flags(flags), .flags_o(flags_o), .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_W:0]   req_q [$];
   logic [DATA_W-1:0] rsp_q [$];
   logic [FLAG_W-1:0] flag_hist [$];
   int  req_out_cnt = 0, rsp_out_cnt = 0, req_acc = 0, rsp_acc = 0;
   int  first_in = -1, first_out = -1, last_out = -1;
   bit  skip_req = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      req_q.delete();
      rsp_q.delete();
      flag_hist.delete();
      for (int i = 0; i < FLAG_STAGES; i++) flag_hist.push_back({FLAG_W{1'b0}});
   endtask

   // One clock: sample handshakes at the falling edge, update models, advance.
   task automatic tick();
      logic [63:0] expv;
      @(negedge clk);
      cyc++;
      chk("flags_o", flags_o, flag_hist[0]);
      flag_hist.push_back(flags);
      void'(flag_hist.pop_front());
      if (!skip_req) chk("parity_err", parity_err, 64'd0);
      if (dn.req_valid && dn.req_ready && !skip_req) begin
         if (req_q.size() > 0) expv = 64'(req_q.pop_front());
         else expv = 64'hDEAD_BEEF_DEAD_BEEF;
         chk("req_word", {dn.req_we, dn.req_data}, expv);
         req_out_cnt++;
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
      end
      if (up.req_valid && up.req_ready && !flush) begin
         req_q.push_back({up.req_we, up.req_data});
         req_acc++;
         if (first_in < 0) first_in = cyc;
      end
      if (up.rsp_valid && up.rsp_ready) begin
         if (rsp_q.size() > 0) expv = 64'(rsp_q.pop_front());
         else expv = 64'hDEAD_BEEF_DEAD_BEEF;
         chk("rsp_word", up.rsp_data, expv);
         rsp_out_cnt++;
      end
      if (dn.rsp_valid && dn.rsp_ready && !flush) begin
         rsp_q.push_back(dn.rsp_data);
         rsp_acc++;
      end
      if (flush) begin
         req_q.delete();
         rsp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      up.req_valid = 1'b0;
      dn.rsp_valid = 1'b0;
      dn.req_ready = 1'b1;
      up.rsp_ready = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < 20 && (req_q.size() > 0 || rsp_q.size() > 0); k++) tick();
      tick();
      chk("drain_req", req_q.size(), 64'd0);
      chk("drain_rsp", rsp_q.size(), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int base;
      bit acc;
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      reset = 1'b1; flush = 1'b0; flags = {FLAG_W{1'b0}};
      up.req_valid = 1'b0; up.req_we = 1'b0; up.req_data = '0; up.rsp_ready = 1'b0;
      dn.req_ready = 1'b0; dn.rsp_valid = 1'b0; dn.rsp_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid_o", dn.req_valid, 64'd0);
      chk("rst_rsp_valid_o", up.rsp_valid, 64'd0);
      chk("rst_flags_o", flags_o, 64'd0);
      chk("rst_parity_err", parity_err, 64'd0);
      model_reset();
      reset = 1'b0;
      tick();
      chk("rst_req_ready", up.req_ready, 64'd1);
      chk("rst_rsp_ready", dn.rsp_ready, 64'd1);

      // 1: stream 0x1..0x10, slave always ready
      dn.req_ready = 1'b1;
      first_in = -1; first_out = -1; base = req_out_cnt;
      for (int i = 1; i <= 16; i++) begin
         up.req_valid = 1'b1; up.req_data = 32'(i); up.req_we = i[0];
         tick();
      end
      up.req_valid = 1'b0;
      repeat (4) tick();
      chk("t1_count", req_out_cnt - base, 64'd16);
      chk("t1_latency", first_out - first_in, 64'(REQ_STAGES));
      chk("t1_throughput", last_out - first_out, 64'd15);

      // 2: stream 0xA0..0xAF with slave ready pattern 1,0,0,1
      idx = 0; base = req_out_cnt;
      for (int k = 0; k < 200 && idx < 16; k++) begin
         up.req_valid = 1'b1; up.req_data = 32'(8'hA0 + idx); up.req_we = 1'b1;
         dn.req_ready = pat[k % 4];
         acc = up.req_ready;
         tick();
         if (acc) idx++;
      end
      chk("t2_sent", idx, 64'd16);
      drain();
      chk("t2_count", req_out_cnt - base, 64'd16);

      // 3: RSP full stall
      up.rsp_ready = 1'b0; rsp_acc = 0;
      for (int k = 0; k < 10; k++) begin
         dn.rsp_valid = 1'b1; dn.rsp_data = $urandom;
         tick();
      end
      chk("t3_accepted", rsp_acc, 64'(2 * RSP_STAGES));
      chk("t3_rsp_ready", dn.rsp_ready, 64'd0);
      base = rsp_out_cnt;
      drain();
      chk("t3_drained", rsp_out_cnt - base, 64'(2 * RSP_STAGES));

      // 4: flush with 3 REQ words held
      dn.req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         up.req_valid = 1'b1; up.req_data = 32'(8'h30 + i); up.req_we = 1'b0;
         tick();
      end
      up.req_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_valid_o", dn.req_valid, 64'd0);
      chk("t4_req_ready", up.req_ready, 64'd1);
      base = req_out_cnt;
      dn.req_ready = 1'b1;
      up.req_valid = 1'b1; up.req_data = 32'h55; up.req_we = 1'b0;
      tick();
      drain();
      chk("t4_count", req_out_cnt - base, 64'd1);

      // 5: single-cycle flag pulse, flush in the following cycle
      flags = 8'h81;
      tick();
      flags = 8'h00;
      chk("t5_flags_hit", flags_o, 64'h81);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flags_after", flags_o, 64'h00);
      tick();

      // randomized traffic with occasional flush
      for (int k = 0; k < 400; k++) begin
         up.req_valid = 1'($urandom); up.req_we = 1'($urandom); up.req_data = $urandom;
         dn.req_ready = ($urandom_range(3) != 0);
         dn.rsp_valid = 1'($urandom); dn.rsp_data = $urandom;
         up.rsp_ready = ($urandom_range(3) != 0);
         flush = ($urandom_range(49) == 0);
         flags = 8'($urandom);
         tick();
      end
      flags = 8'h00;
      drain();

`ifdef BUS_PIPE_PARITY_EN
      // 6: corrupt a held REQ word at the last stage and deliver it
      skip_req = 1'b1;
      dn.req_ready = 1'b0;
      up.req_valid = 1'b1; up.req_data = 32'h10; up.req_we = 1'b0;
      tick();
      up.req_valid = 1'b0;
      repeat (2) tick();
      force dut.g_req[REQ_STAGES-1].u_stage.out_data_q[0] = 1'b1;
      dn.req_ready = 1'b1;
      tick();
      release dut.g_req[REQ_STAGES-1].u_stage.out_data_q[0];
      chk("t6_parity_set", parity_err, 64'd1);
      repeat (3) tick();
      chk("t6_parity_sticky", parity_err, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      skip_req = 1'b0;
      chk("t6_parity_clear", parity_err, 64'd0);
      tick();
`else
      chk("t6_parity_off", parity_err, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
